// File: rtl/dma_tx_pkg.sv
// dma_tx_pkg: shared types and constants for the DMA TX completion path.
package dma_tx_pkg;
    localparam int DMA_DATA_BITS = 3;
    localparam int DMA_RAM_ADDR_WIDTH = 18;
    localparam int DMA_BEAT_BYTES = 1 << DMA_DATA_BITS;
    localparam int DMA_WADDR_BITS = DMA_RAM_ADDR_WIDTH - DMA_DATA_BITS;

    typedef struct packed {
        logic                      valid;
        logic [DMA_WADDR_BITS-1:0] wptr;
        logic [DMA_WADDR_BITS-1:0] wend;
    } dma_tx_ctx_t;

    typedef enum logic {ST_IDLE, ST_PAYLOAD} dma_tx_beat_st_t;
endpackage

// File: rtl/dma_tx_cpl_ctx.sv
// dma_tx_cpl_ctx: per-tag context register file; request write port, completion update port, combinational read.
module dma_tx_cpl_ctx
    import dma_tx_pkg::*;
#(
    parameter int TW = 4,
    parameter int LW = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic [TW-1:0]             req_tag,
    input  logic [DMA_WADDR_BITS-1:0] req_laddr,
    input  logic [LW-1:0]             req_length,
    input  logic [TW-1:0]             rd_tag,
    output dma_tx_ctx_t               rd_ctx,
    input  logic                      upd_valid,
    input  logic [TW-1:0]             upd_tag,
    input  logic                      upd_keep,
    input  logic [DMA_WADDR_BITS-1:0] upd_wptr
);
    localparam int AW = DMA_WADDR_BITS;

    logic [2**TW-1:0] vld;
    logic [AW-1:0]    wptr [2**TW];
    logic [AW-1:0]    wend [2**TW];

    // request write follows the update so it wins on a same-tag collision
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            if (upd_valid) vld[upd_tag] <= upd_keep;
            if (req_valid) vld[req_tag] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_valid) wptr[upd_tag] <= upd_wptr;
        if (req_valid) begin
            wptr[req_tag] <= req_laddr;
            wend[req_tag] <= req_laddr + AW'(req_length) + AW'(1);
        end
    end

    assign rd_ctx = '{valid: vld[rd_tag], wptr: wptr[rd_tag], wend: wend[rd_tag]};
endmodule

// File: rtl/dma_tx_cpl_reasm.sv
// dma_tx_cpl_reasm: places PCIe completion beats into staging RAM by tag context and
// returns each tag once its full payload has landed.
module dma_tx_cpl_reasm
    import dma_tx_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH   = 18,
    parameter int DATA_BITS        = 3,
    parameter int REQUEST_LEN_BITS = 12,
    parameter int PCIE_TAG_BITS    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                s_req_valid,
    input  logic [PCIE_TAG_BITS-1:0]            s_req_tag,
    input  logic [RAM_ADDR_WIDTH-DATA_BITS-1:0] s_req_laddr,
    input  logic [REQUEST_LEN_BITS-DATA_BITS-1:0] s_req_length,
    input  logic                                s_cpl_valid,
    output logic                                s_cpl_ready,
    input  logic [(8<<DATA_BITS)-1:0]           s_cpl_data,
    input  logic [PCIE_TAG_BITS-1:0]            s_cpl_tag,
    input  logic                                s_cpl_sop,
    input  logic                                s_cpl_eop,
    input  logic                                s_cpl_final,
    output logic                                m_ram_we,
    output logic [RAM_ADDR_WIDTH-DATA_BITS-1:0] m_ram_addr,
    output logic [(8<<DATA_BITS)-1:0]           m_ram_data,
    output logic                                m_done_valid,
    input  logic                                m_done_ready,
    output logic [PCIE_TAG_BITS-1:0]            m_done_tag,
    output logic                                err_unexp_tag,
    output logic                                err_overrun,
    output logic                                err_short
);
    localparam int AW = RAM_ADDR_WIDTH - DATA_BITS;
    localparam int LW = REQUEST_LEN_BITS - DATA_BITS;
    localparam int TW = PCIE_TAG_BITS;

    dma_tx_beat_st_t state, state_nxt;
    dma_tx_ctx_t     rd_ctx;
    logic [TW-1:0]   cur_tag, e_tag;
    logic            cur_final, cur_ok, e_final, e_ok;
    logic [AW-1:0]   cur_wptr, cur_wend, e_wptr, e_wend, nxt_wptr;
    logic            acc, in_sop, wr, eop, fin;

    dma_tx_cpl_ctx #(.TW(TW), .LW(LW)) u_ctx (
        .clk       (clk),
        .rst       (rst),
        .req_valid (s_req_valid),
        .req_tag   (s_req_tag),
        .req_laddr (s_req_laddr),
        .req_length(s_req_length),
        .rd_tag    (s_cpl_tag),
        .rd_ctx    (rd_ctx),
        .upd_valid (eop && e_ok),
        .upd_tag   (e_tag),
        .upd_keep  (!e_final),
        .upd_wptr  (nxt_wptr)
    );

    assign s_cpl_ready = !(m_done_valid && !m_done_ready);

    // a beat seen in IDLE without sop is a stray remainder and never matches a context
    always_comb begin
        acc       = s_cpl_valid && s_cpl_ready;
        in_sop    = state == ST_IDLE;
        e_tag     = in_sop ? s_cpl_tag : cur_tag;
        e_ok      = in_sop ? s_cpl_sop && rd_ctx.valid : cur_ok;
        e_final   = in_sop ? s_cpl_final : cur_final;
        e_wptr    = in_sop ? rd_ctx.wptr : cur_wptr;
        e_wend    = in_sop ? rd_ctx.wend : cur_wend;
        wr        = acc && e_ok && e_wptr != e_wend;
        nxt_wptr  = e_wptr + AW'(wr);
        eop       = acc && s_cpl_eop && (!in_sop || s_cpl_sop);
        fin       = eop && e_ok && e_final;
        state_nxt = !acc ? state :
                    in_sop ? ((s_cpl_sop && !s_cpl_eop) ? ST_PAYLOAD : ST_IDLE) :
                    (s_cpl_eop ? ST_IDLE : ST_PAYLOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            m_ram_we      <= 1'b0;
            m_done_valid  <= 1'b0;
            err_unexp_tag <= 1'b0;
            err_overrun   <= 1'b0;
            err_short     <= 1'b0;
        end else begin
            state         <= state_nxt;
            m_ram_we      <= wr;
            err_unexp_tag <= err_unexp_tag || (acc && !e_ok);
            err_overrun   <= err_overrun || (acc && e_ok && e_wptr == e_wend);
            err_short     <= err_short || (fin && nxt_wptr != e_wend);
            m_done_valid  <= fin || (m_done_valid && !m_done_ready);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            m_ram_addr <= e_wptr;
            m_ram_data <= s_cpl_data;
        end
        if (fin) m_done_tag <= e_tag;
        if (acc) begin
            cur_tag   <= e_tag;
            cur_final <= e_final;
            cur_ok    <= e_ok;
            cur_wptr  <= nxt_wptr;
            cur_wend  <= e_wend;
        end
    end
endmodule

// File: tb/tb_dma_tx_cpl_reasm.sv
// tb_dma_tx_cpl_reasm: directed scenario tests for the completion reassembler.
module tb_dma_tx_cpl_reasm;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_req_valid;
    logic [3:0]  s_req_tag;
    logic [14:0] s_req_laddr;
    logic [8:0]  s_req_length;
    logic        s_cpl_valid, s_cpl_ready;
    logic [63:0] s_cpl_data;
    logic [3:0]  s_cpl_tag;
    logic        s_cpl_sop, s_cpl_eop, s_cpl_final;
    logic        m_ram_we;
    logic [14:0] m_ram_addr;
    logic [63:0] m_ram_data;
    logic        m_done_valid, m_done_ready;
    logic [3:0]  m_done_tag;
    logic        err_unexp_tag, err_overrun, err_short;

    int total = 0;
    int bad = 0;
    int stalls = 0;
    logic [78:0] wq[$];
    logic [3:0]  dq[$];

    always #5 clk = ~clk;

    dma_tx_cpl_reasm dut (
        .clk(clk), .rst(rst),
        .s_req_valid(s_req_valid), .s_req_tag(s_req_tag), .s_req_laddr(s_req_laddr), .s_req_length(s_req_length),
        .s_cpl_valid(s_cpl_valid), .s_cpl_ready(s_cpl_ready), .s_cpl_data(s_cpl_data), .s_cpl_tag(s_cpl_tag),
        .s_cpl_sop(s_cpl_sop), .s_cpl_eop(s_cpl_eop), .s_cpl_final(s_cpl_final),
        .m_ram_we(m_ram_we), .m_ram_addr(m_ram_addr), .m_ram_data(m_ram_data),
        .m_done_valid(m_done_valid), .m_done_ready(m_done_ready), .m_done_tag(m_done_tag),
        .err_unexp_tag(err_unexp_tag), .err_overrun(err_overrun), .err_short(err_short)
    );

    always @(negedge clk) begin
        if (m_ram_we) wq.push_back({m_ram_addr, m_ram_data});
        if (m_done_valid && m_done_ready) dq.push_back(m_done_tag);
    end

    function automatic logic [78:0] wexp(input logic [14:0] a, input logic [3:0] tag, input int off);
        return {a, 28'h0, tag, 32'(off)};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        s_req_valid = 1'b0; s_req_tag = '0; s_req_laddr = '0; s_req_length = '0;
        s_cpl_valid = 1'b0; s_cpl_data = '0; s_cpl_tag = '0;
        s_cpl_sop = 1'b0; s_cpl_eop = 1'b0; s_cpl_final = 1'b0;
        m_done_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wq.delete();
        dq.delete();
    endtask

    task automatic send_req(input logic [3:0] tag, input logic [14:0] la, input logic [8:0] len);
        s_req_valid = 1'b1; s_req_tag = tag; s_req_laddr = la; s_req_length = len;
        @(posedge clk);
        #1 s_req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [3:0] tag, input logic sop, input logic eop, input logic fin, input int off);
        bit acc = 1'b0;
        int n = 0;
        s_cpl_valid = 1'b1; s_cpl_tag = tag; s_cpl_sop = sop; s_cpl_eop = eop; s_cpl_final = fin;
        s_cpl_data = {28'h0, tag, 32'(off)};
        while (!acc) begin
            @(negedge clk);
            acc = s_cpl_ready;
            if (!acc) stalls++;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 100) begin
                total++; bad++;
                $display("FAIL beat_timeout tag=%0d off=%0d got=no_accept exp=accept", tag, off);
                break;
            end
        end
        s_cpl_valid = 1'b0;
    endtask

    task automatic send_tlp(input logic [3:0] tag, input logic fin, input int off0, input int n);
        for (int i = 0; i < n; i++) send_beat(tag, i == 0, i == n - 1, fin, off0 + i);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({m_ram_we, m_done_valid, s_cpl_ready} !== 3'b001) begin
            bad++; $display("FAIL reset_out got=%b exp=001", {m_ram_we, m_done_valid, s_cpl_ready});
        end
        total++;
        if ({err_unexp_tag, err_overrun, err_short} !== 3'b000) begin
            bad++; $display("FAIL reset_err got=%b exp=000", {err_unexp_tag, err_overrun, err_short});
        end
    endtask

    task automatic test_basic();
        do_reset();
        send_req(4'd3, 15'h100, 9'd15);
        send_tlp(4'd3, 1'b1, 0, 16);
        total++;
        if (m_done_valid !== 1'b1 || m_done_tag !== 4'd3) begin
            bad++; $display("FAIL basic_done_latency got=%b/%0d exp=1/3", m_done_valid, m_done_tag);
        end
        total++;
        if (m_ram_we !== 1'b1 || m_ram_addr !== 15'h10F) begin
            bad++; $display("FAIL basic_wr_latency got=%b/%h exp=1/10f", m_ram_we, m_ram_addr);
        end
        settle();
        total++;
        if (wq.size() != 16) begin bad++; $display("FAIL basic_wcount got=%0d exp=16", wq.size()); end
        for (int i = 0; i < wq.size() && i < 16; i++) begin
            total++;
            if (wq[i] !== wexp(15'h100 + 15'(i), 4'd3, i)) begin
                bad++; $display("FAIL basic_write[%0d] got=%h exp=%h", i, wq[i], wexp(15'h100 + 15'(i), 4'd3, i));
            end
        end
        total++;
        if (dq.size() != 1 || dq[0] !== 4'd3) begin bad++; $display("FAIL basic_done got=%0d entries exp=1 of tag 3", dq.size()); end
        total++;
        if ({err_unexp_tag, err_overrun, err_short} !== 3'b000) begin
            bad++; $display("FAIL basic_err got=%b exp=000", {err_unexp_tag, err_overrun, err_short});
        end
    endtask

    task automatic test_split();
        do_reset();
        send_req(4'd5, 15'h300, 9'd31);
        send_tlp(4'd5, 1'b0, 0, 16);
        settle();
        total++;
        if (dq.size() != 0) begin bad++; $display("FAIL split_early_done got=%0d exp=0", dq.size()); end
        send_tlp(4'd5, 1'b1, 16, 16);
        settle();
        total++;
        if (wq.size() != 32) begin bad++; $display("FAIL split_wcount got=%0d exp=32", wq.size()); end
        for (int i = 0; i < wq.size() && i < 32; i++) begin
            total++;
            if (wq[i] !== wexp(15'h300 + 15'(i), 4'd5, i)) begin
                bad++; $display("FAIL split_write[%0d] got=%h exp=%h", i, wq[i], wexp(15'h300 + 15'(i), 4'd5, i));
            end
        end
        total++;
        if (dq.size() != 1 || dq[0] !== 4'd5) begin bad++; $display("FAIL split_done got=%0d entries exp=1 of tag 5", dq.size()); end
        total++;
        if ({err_unexp_tag, err_overrun, err_short} !== 3'b000) begin
            bad++; $display("FAIL split_err got=%b exp=000", {err_unexp_tag, err_overrun, err_short});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  t;
        logic [14:0] a;
        do_reset();
        send_req(4'd1, 15'h010, 9'd7);
        send_req(4'd2, 15'h020, 9'd7);
        send_tlp(4'd1, 1'b0, 0, 4);
        send_tlp(4'd2, 1'b0, 0, 4);
        m_done_ready = 1'b0;
        send_tlp(4'd1, 1'b1, 4, 4);
        total++;
        if (s_cpl_ready !== 1'b0 || m_done_valid !== 1'b1 || m_done_tag !== 4'd1) begin
            bad++; $display("FAIL b2b_stall got=rdy%b/dv%b/tag%0d exp=rdy0/dv1/tag1", s_cpl_ready, m_done_valid, m_done_tag);
        end
        stalls = 0;
        fork
            send_tlp(4'd2, 1'b1, 4, 4);
            begin
                repeat (5) @(posedge clk);
                #1 m_done_ready = 1'b1;
            end
        join
        settle();
        total++;
        if (stalls != 5) begin bad++; $display("FAIL b2b_stall_cycles got=%0d exp=5", stalls); end
        total++;
        if (wq.size() != 16) begin bad++; $display("FAIL b2b_wcount got=%0d exp=16", wq.size()); end
        for (int i = 0; i < wq.size() && i < 16; i++) begin
            t = ((i / 4) % 2 == 1) ? 4'd2 : 4'd1;
            a = ((t == 4'd1) ? 15'h010 : 15'h020) + 15'((i / 8) * 4 + i % 4);
            total++;
            if (wq[i] !== wexp(a, t, (i / 8) * 4 + i % 4)) begin
                bad++; $display("FAIL b2b_write[%0d] got=%h exp=%h", i, wq[i], wexp(a, t, (i / 8) * 4 + i % 4));
            end
        end
        total++;
        if (dq.size() != 2 || dq[0] !== 4'd1 || dq[1] !== 4'd2) begin
            bad++; $display("FAIL b2b_done_order got=%0d entries exp=2 (1 then 2)", dq.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        send_req(4'd7, 15'h7FFC, 9'd7);
        send_tlp(4'd7, 1'b1, 0, 8);
        settle();
        total++;
        if (wq.size() != 8) begin bad++; $display("FAIL wrap_wcount got=%0d exp=8", wq.size()); end
        for (int i = 0; i < wq.size() && i < 8; i++) begin
            total++;
            if (wq[i] !== wexp(15'h7FFC + 15'(i), 4'd7, i)) begin
                bad++; $display("FAIL wrap_write[%0d] got=%h exp=%h", i, wq[i], wexp(15'h7FFC + 15'(i), 4'd7, i));
            end
        end
        total++;
        if (dq.size() != 1 || dq[0] !== 4'd7 || err_short !== 1'b0) begin
            bad++; $display("FAIL wrap_done got=%0d entries short=%b exp=1 entry of tag 7, short=0", dq.size(), err_short);
        end
    endtask

    task automatic test_errors();
        do_reset();
        send_tlp(4'd9, 1'b1, 0, 2);
        settle();
        total++;
        if (wq.size() != 0 || dq.size() != 0) begin
            bad++; $display("FAIL unexp_activity got=%0d writes %0d dones exp=0 0", wq.size(), dq.size());
        end
        total++;
        if ({err_unexp_tag, err_overrun, err_short} !== 3'b100) begin
            bad++; $display("FAIL unexp_err got=%b exp=100", {err_unexp_tag, err_overrun, err_short});
        end
        do_reset();
        send_req(4'd4, 15'h200, 9'd3);
        send_tlp(4'd4, 1'b1, 0, 5);
        settle();
        total++;
        if (wq.size() != 4) begin bad++; $display("FAIL overrun_wcount got=%0d exp=4", wq.size()); end
        for (int i = 0; i < wq.size() && i < 4; i++) begin
            total++;
            if (wq[i] !== wexp(15'h200 + 15'(i), 4'd4, i)) begin
                bad++; $display("FAIL overrun_write[%0d] got=%h exp=%h", i, wq[i], wexp(15'h200 + 15'(i), 4'd4, i));
            end
        end
        total++;
        if ({err_unexp_tag, err_overrun, err_short} !== 3'b010) begin
            bad++; $display("FAIL overrun_err got=%b exp=010", {err_unexp_tag, err_overrun, err_short});
        end
        total++;
        if (dq.size() != 1 || dq[0] !== 4'd4) begin bad++; $display("FAIL overrun_done got=%0d entries exp=1 of tag 4", dq.size()); end
        do_reset();
        send_req(4'd8, 15'h050, 9'd7);
        send_tlp(4'd8, 1'b1, 0, 4);
        settle();
        total++;
        if ({err_unexp_tag, err_overrun, err_short} !== 3'b001 || wq.size() != 4) begin
            bad++; $display("FAIL short_err got=%b/%0d writes exp=001/4", {err_unexp_tag, err_overrun, err_short}, wq.size());
        end
        total++;
        if (dq.size() != 1 || dq[0] !== 4'd8) begin bad++; $display("FAIL short_done got=%0d entries exp=1 of tag 8", dq.size()); end
    endtask

    task automatic test_reset_mid();
        int n0;
        do_reset();
        send_req(4'd6, 15'h040, 9'd7);
        for (int i = 0; i < 4; i++) send_beat(4'd6, i == 0, 1'b0, 1'b1, i);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n0 = wq.size();
        total++;
        if (n0 != 4) begin bad++; $display("FAIL rstmid_pre_writes got=%0d exp=4", n0); end
        for (int i = 4; i < 8; i++) send_beat(4'd6, 1'b0, i == 7, 1'b1, i);
        settle();
        total++;
        if (wq.size() != 4) begin bad++; $display("FAIL rstmid_post_writes got=%0d exp=4", wq.size()); end
        total++;
        if (err_unexp_tag !== 1'b1) begin bad++; $display("FAIL rstmid_unexp got=%b exp=1", err_unexp_tag); end
        total++;
        if (dq.size() != 0 || m_done_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_done got=%0d entries dv=%b exp=0/0", dq.size(), m_done_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_split();
        test_back_to_back();
        test_wrap();
        test_errors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
